// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of a 5-stage RV32 pipeline.
//
// Owns the PC and drives it to a combinational-read instruction memory.
// Captures the returned word into the IF/ID register. Handles hazard
// stalls, EX-stage redirects and bad-PC faults, and counts retired fetches.
//
// State table:
//   state | meaning
//   BOOT  | first edge after reset release, no fetch
//   RUN   | normal fetch (priority: redirect > fault > stall > fetch)
//   FAULT | bad PC seen; PC and IF/ID held until a redirect arrives
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   stall_i             hazard hold (ignored in BOOT and FAULT)
//   redirect_valid_i/   taken branch/jump target from EX
//   redirect_pc_i
//   imem_addr_o         byte address to imem (= PC register)
//   imem_instr_i        instruction for imem_addr_o, same cycle
//   ifid_*_o            IF/ID pipeline register contents
//   fault_o/fault_pc_o  fetch fault flag and offending PC
//   fetch_count_o       number of valid instructions captured into IF/ID
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc_plus4_o,
  output logic [31:0] ifid_instr_o,
  output logic        fault_o,
  output logic [31:0] fault_pc_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;
  logic        bad;

  assign pc_plus4 = pc_q + 32'd4;
  // Word index compared zero-extended so any IMEM_WORDS value is legal.
  assign bad = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= IMEM_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      fault_q      <= 1'b0;
      fault_pc_q   <= 32'd0;
      count_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      fault_q      <= fault_d;
      fault_pc_q   <= fault_pc_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    fault_d      = fault_q;
    fault_pc_d   = fault_pc_q;
    count_d      = count_q;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect_valid_i) begin
          pc_d         = redirect_pc_i;
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end else if (bad) begin
          state_d      = FAULT;
          fault_d      = 1'b1;
          fault_pc_d   = pc_q;
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end else if (!stall_i) begin
          ifid_valid_d = 1'b1;
          ifid_pc_d    = pc_q;
          ifid_pc4_d   = pc_plus4;
          ifid_instr_d = imem_instr_i;
          pc_d         = pc_plus4;
          count_d      = count_q + 32'd1;
        end
      end
      FAULT: begin
        // IF/ID was already turned into a bubble on entry; re-asserting keeps it so.
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
        if (redirect_valid_i) begin
          pc_d    = redirect_pc_i;
          fault_d = 1'b0;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign imem_addr_o     = pc_q;
  assign ifid_valid_o    = ifid_valid_q;
  assign ifid_pc_o       = ifid_pc_q;
  assign ifid_pc_plus4_o = ifid_pc4_q;
  assign ifid_instr_o    = ifid_instr_q;
  assign fault_o         = fault_q;
  assign fault_pc_o      = fault_pc_q;
  assign fetch_count_o   = count_q;

endmodule
